// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush/clear controls, EX forwarding selects, data-memory wait FSM.
// Controls are combinational from current inputs and FSM state; a MEM miss freezes the pipe with zero latency.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    Rs1D,
  input  logic [4:0]    Rs2D,
  input  logic [4:0]    Rs1E,
  input  logic [4:0]    Rs2E,
  input  logic [4:0]    RdE,
  input  logic [4:0]    RdM,
  input  logic [4:0]    RdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          LoadE,
  input  logic          PCSrcE,
  input  logic          MemReqM,
  input  logic          MemReadyM,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          StallM,
  output logic          FlushD,
  output logic          FlushE,
  output logic          ClearW,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          MemBusy,
  output logic          MemErr,
  output logic [CW-1:0] StallCount
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic [CW-1:0] stall_cnt;
  logic          mem_stall;
  logic          lw_stall;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // wait_cnt counts cycles spent in WAIT; timeout fires on the MAX_WAIT-th unanswered one
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_stall    = 1'b0;
    case (state)
      S_RUN: begin
        if (MemReqM && !MemReadyM) begin
          mem_stall    = 1'b1;
          state_nxt    = S_WAIT;
          wait_cnt_nxt = CW'(1);
        end
      end
      S_WAIT: begin
        if (MemReadyM) begin
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt >= MAX_W)
            state_nxt = S_ERR;
          else
            wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      S_ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_nxt    = S_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Controls are forced quiet while reset is held, independent of the clock
  assign StallF    = reset & (mem_stall | lw_stall);
  assign StallD    = reset & (mem_stall | lw_stall);
  assign StallE    = reset & mem_stall;
  assign StallM    = reset & mem_stall;
  assign ClearW    = reset & mem_stall;
  assign FlushD    = reset & PCSrcE & ~mem_stall;
  assign FlushE    = reset & (lw_stall | PCSrcE) & ~mem_stall;
  assign ForwardAE = reset ? fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW) : 2'b00;
  assign ForwardBE = reset ? fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW) : 2'b00;

  assign MemBusy    = (state == S_WAIT);
  assign MemErr     = (state == S_ERR);
  assign StallCount = stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (StallF && (stall_cnt != {CW{1'b1}}))
      stall_cnt <= stall_cnt + CW'(1);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written multi-cycle sequences, randomized run vs a reference model.
module tb_pipe_hazard_ctrl;

  localparam int MAXW = 4;
  localparam int CW   = 8;
  localparam int SAT  = (1 << CW) - 1;

  logic clk, reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, ClearW, MemBusy, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCount;
  logic [10:0] ctl;

  int total = 0;
  int passed = 0;

  // reference model state
  bit m_waiting, m_err;
  int m_waited, m_stalls;

  pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ClearW(ClearW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemBusy(MemBusy), .MemErr(MemErr), .StallCount(StallCount)
  );

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, ClearW, ForwardAE, ForwardBE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic rwm, rww, loade, pcsrc;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                               input logic rwm, rww, loade, pcsrc, input logic [10:0] exp);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
    v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww; v.loade = loade; v.pcsrc = pcsrc;
    v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    reset = 1'b0;
    m_waiting = 0; m_err = 0; m_waited = 0; m_stalls = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] model_ctl();
    bit ms, lw;
    ms = m_err || (!MemReadyM && (m_waiting || MemReqM));
    lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    return {ms | lw, ms | lw, ms, ms, PCSrcE & !ms, (lw | PCSrcE) & !ms, ms,
            model_fwd(Rs1E), model_fwd(Rs2E)};
  endfunction

  // Advance the model across one clock edge using the current inputs
  task automatic model_edge();
    logic [10:0] c;
    c = model_ctl();
    if (c[10] && m_stalls < SAT) m_stalls++;
    if (m_err) begin
    end else if (m_waiting) begin
      if (MemReadyM) begin
        m_waiting = 0;
      end else if (m_waited >= MAXW) begin
        m_waiting = 0;
        m_err = 1;
      end else begin
        m_waited++;
      end
    end else if (MemReqM && !MemReadyM) begin
      m_waiting = 1;
      m_waited = 1;
    end
  endtask

  initial begin
    int nstall;

    // Reset state: hazardous inputs, everything must read quiet
    clear_inputs();
    reset = 1'b0;
    LoadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1; MemReqM = 1'b1;
    RegWriteM = 1'b1; RdM = 5'd2; Rs1E = 5'd2;
    #3;
    check("reset_ctl", 32'(ctl), 32'd0);
    check("reset_busy", 32'(MemBusy), 32'd0);
    check("reset_err", 32'(MemErr), 32'd0);
    check("reset_cnt", 32'(StallCount), 32'd0);
    tick();
    tick();
    check("reset_ctl_held", 32'(ctl), 32'd0);

    // Combinational table: forwarding, load-use, branch
    vecs.push_back(mkv(0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 11'b0000000_10_00));
    vecs.push_back(mkv(0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 11'b0000000_01_00));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 11'b0000000_00_00));
    vecs.push_back(mkv(0, 0, 4, 3, 0, 4, 3, 1, 1, 0, 0, 11'b0000000_10_01));
    vecs.push_back(mkv(0, 0, 6, 6, 0, 6, 6, 1, 1, 0, 0, 11'b0000000_10_10));
    vecs.push_back(mkv(1, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 11'b1100010_00_00));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 11'b0000000_00_00));
    vecs.push_back(mkv(7, 2, 0, 0, 7, 0, 0, 0, 0, 1, 1, 11'b1100110_00_00));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11'b0000110_00_00));
    vecs.push_back(mkv(7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 11'b0000000_00_00));
    vecs.push_back(mkv(0, 9, 0, 9, 0, 0, 9, 1, 0, 0, 0, 11'b0000000_00_00));

    reset_dut();
    nstall = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; LoadE = vecs[i].loade; PCSrcE = vecs[i].pcsrc;
      #4;
      check($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp));
      if (vecs[i].exp[10]) nstall++;
      tick();
    end
    clear_inputs();
    #4;
    check("vec_stallcount", 32'(StallCount), 32'(nstall));

    // Memory wait: 3 miss cycles then ready
    reset_dut();
    MemReqM = 1'b1;
    #4;
    check("mw_c1_ctl", 32'(ctl), 32'(11'b1111001_00_00));
    check("mw_c1_busy", 32'(MemBusy), 32'd0);
    tick(); #4;
    check("mw_c2_ctl", 32'(ctl), 32'(11'b1111001_00_00));
    check("mw_c2_busy", 32'(MemBusy), 32'd1);
    tick(); #4;
    check("mw_c3_ctl", 32'(ctl), 32'(11'b1111001_00_00));
    check("mw_c3_busy", 32'(MemBusy), 32'd1);
    tick();
    MemReadyM = 1'b1;
    #4;
    check("mw_ready_ctl", 32'(ctl), 32'd0);
    tick();
    MemReqM = 1'b0; MemReadyM = 1'b0;
    #4;
    check("mw_run_busy", 32'(MemBusy), 32'd0);
    check("mw_stallcount", 32'(StallCount), 32'd3);

    // Branch held during a 2-cycle miss: flush deferred to release cycle
    reset_dut();
    PCSrcE = 1'b1; MemReqM = 1'b1;
    #4;
    check("br_miss1_ctl", 32'(ctl), 32'(11'b1111001_00_00));
    tick(); #4;
    check("br_miss2_ctl", 32'(ctl), 32'(11'b1111001_00_00));
    tick();
    MemReadyM = 1'b1;
    #4;
    check("br_release_ctl", 32'(ctl), 32'(11'b0000110_00_00));

    // Timeout into ERR, then stall counter saturation
    reset_dut();
    MemReqM = 1'b1;
    for (int i = 0; i < MAXW; i++) tick();
    #4;
    check("to_lastwait_err", 32'(MemErr), 32'd0);
    check("to_lastwait_busy", 32'(MemBusy), 32'd1);
    tick(); #4;
    check("to_err", 32'(MemErr), 32'd1);
    check("to_err_busy", 32'(MemBusy), 32'd0);
    MemReqM = 1'b0; MemReadyM = 1'b1;
    #1;
    check("to_err_ready_ctl", 32'(ctl), 32'(11'b1111001_00_00));
    repeat (300) tick();
    check("to_err_sticky", 32'(MemErr), 32'd1);
    check("stallcount_sat", 32'(StallCount), 32'(SAT));

    // Async reset mid-WAIT with StallCount at 9
    reset_dut();
    LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    repeat (7) tick();
    LoadE = 1'b0; RdE = 5'd0; Rs1D = 5'd0;
    MemReqM = 1'b1; PCSrcE = 1'b1;
    tick();
    tick();
    #1;
    check("ar_pre_cnt", 32'(StallCount), 32'd9);
    check("ar_pre_busy", 32'(MemBusy), 32'd1);
    reset = 1'b0;
    #1;
    check("ar_ctl", 32'(ctl), 32'd0);
    check("ar_busy", 32'(MemBusy), 32'd0);
    check("ar_cnt", 32'(StallCount), 32'd0);
    check("ar_err", 32'(MemErr), 32'd0);
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(); #4;
    check("ar_run_busy", 32'(MemBusy), 32'd0);
    check("ar_run_ctl", 32'(ctl), 32'd0);

    // Randomized run against the reference model
    reset_dut();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [10:0] e;
      if (m_err && $urandom_range(0, 3) == 0) begin
        reset_dut();
        #1;
        check("rnd_after_reset_cnt", 32'(StallCount), 32'd0);
      end
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      LoadE = ($urandom_range(0, 2) == 0); PCSrcE = ($urandom_range(0, 4) == 0);
      MemReqM = ($urandom_range(0, 2) == 0); MemReadyM = ($urandom_range(0, 3) != 0);
      #4;
      e = model_ctl();
      check("rnd_ctl", 32'(ctl), 32'(e));
      check("rnd_busy", 32'(MemBusy), 32'(m_waiting));
      check("rnd_err", 32'(MemErr), 32'(m_err));
      check("rnd_cnt", 32'(StallCount), 32'(m_stalls));
      model_edge();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates the per-stage stall and clear controls, and the EX-stage forwarding selects.
- Runs a data-memory wait FSM that freezes the pipeline while a MEM-stage access is outstanding, and latches a sticky error on timeout.
- Counts stall cycles for performance observation.

Parameters:
- MAX_WAIT, 16: maximum consecutive memory-wait cycles before timeout; legal range 1..2^CW-1.
- CW, 8: width of the wait counter and the stall counter.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Rs1D, Rs2D  in  5  source registers of the instruction in ID.
- Rs1E, Rs2E, RdE  in  5  source and destination registers of the instruction in EX.
- RdM, RdW  in  5  destination registers in MEM and WB.
- RegWriteM, RegWriteW  in  1  register-write enable in MEM and WB.
- LoadE  in  1  instruction in EX is a load.
- PCSrcE  in  1  branch/jump taken, resolved in EX.
- MemReqM  in  1  instruction in MEM accesses data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE  out  1  clear IF/ID and ID/EX (bubble).
- ClearW  out  1  clear MEM/WB (bubble into WB).
- ForwardAE, ForwardBE  out  2  EX operand select: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- MemBusy  out  1  FSM in WAIT.
- MemErr  out  1  sticky timeout flag.
- StallCount  out  CW  saturating count of stall cycles.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM -> RUN; wait counter, StallCount and MemErr cleared to 0.
  - While reset is low, every stall, flush and clear output is 0 and ForwardAE/ForwardBE are 00, regardless of inputs.
- FSM states RUN, WAIT, ERR; registered.
  - RUN -> WAIT when MemReqM=1 and MemReadyM=0; wait counter loads 1.
  - WAIT -> RUN when MemReadyM=1; wait counter cleared.
  - In WAIT with MemReadyM=0, the wait counter increments; on reaching MAX_WAIT -> ERR.
  - ERR is terminal until reset; MemErr=1 from the first ERR cycle.
- memStall (combinational) = (RUN and MemReqM and !MemReadyM) or (WAIT and !MemReadyM) or ERR.
  - The first miss cycle stalls the pipeline with zero latency.
  - The ready cycle releases the stall in that same cycle.
- lwStall = LoadE and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
- Stall and flush outputs, with memory stall taking priority:
  - StallF = StallD = memStall | lwStall.
  - StallE = StallM = memStall.
  - ClearW = memStall: WB receives a bubble while MEM is held, so there is no duplicate writeback.
  - FlushD = PCSrcE & !memStall.
  - FlushE = (lwStall | PCSrcE) & !memStall.
  - Because EX is frozen during memStall, PCSrcE and lwStall re-evaluate after release; the deferred flush is not lost.
- Forwarding, per operand (Rs1E -> ForwardAE, Rs2E -> ForwardBE):
  - 10 if RegWriteM and RdM != 0 and RdM == RsE.
  - Else 01 if RegWriteW and RdW != 0 and RdW == RsE.
  - Else 00.
  - MEM has priority over WB when both match. x0 is never forwarded.
- StallCount: +1 on every clock where StallF=1; saturates at 2^CW-1 with no wrap.
- Simultaneous lwStall and PCSrcE (no memStall): StallF=StallD=1, FlushD=1, FlushE=1; branch redirect wins for the fetched path.
- Reset asserted mid-WAIT: immediate return to RUN; all outputs take the reset values above.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01. Then RdM=RdW=0 with Rs1E=0 -> ForwardAE=00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0, FlushD=0. Same with RdE=0 -> all 0. StallCount increments by 1 per asserted cycle.
- Memory wait: MemReqM=1 with MemReadyM low for 3 cycles, then high. Required: StallF..StallM=ClearW=1 for exactly 3 cycles; MemBusy=1 for cycles 2-3; outputs return to 0 in the ready cycle; state RUN; StallCount=3.
- Timeout: MAX_WAIT=4, MemReqM=1, MemReadyM held 0 -> ERR entered after 4 WAIT cycles. MemErr=1 and all stalls stay 1 even after MemReadyM=1, until reset=0.
- Branch during memory stall: PCSrcE=1 held during a 2-cycle miss -> FlushD=FlushE=0 during the miss; FlushD=FlushE=1 in the release cycle.
- Async reset: pull reset=0 between clock edges while in WAIT with StallCount=9. Required: MemBusy, StallCount, MemErr and all stall/flush outputs go to 0 immediately, without waiting for a clk edge; RUN on release.
